cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_fill_fsm_fill_counter.sv | 23 ++
 rtl/cache_fill_fsm.sv | 131 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill controller: state encoding and
// block geometry (8 words of 16 bits, 4 byte-offset bits).
package cache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 4;
    localparam int WORD_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: 3-bit word index plus a done flag that sets
// when the index wraps 7 -> 0; further increments are ignored once done.
module fill_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] idx,
    output logic                  done
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx  <= '0;
            done <= 1'b0;
        end else if (inc && !done) begin
            {done, idx} <= {done, idx} + 4'd1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller: issues 8 word reads to memory4c, writes
// returned words into the data array, then writes the tag once.
// Optional macro CACHE_FILL_CWF_EN selects critical-word-first ordering.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        fill_word_sel,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    fill_state_t state_q, state_d;
    logic [ADDR_W-1:0]     base_q;
    logic [WORD_IDX_W-1:0] issue_idx, recv_idx;
    logic [WORD_IDX_W-1:0] issue_word, recv_word;
    logic                  issue_done, recv_done;
    logic                  capture;

    assign capture = (state_q == IDLE) && miss_detected;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (capture),
        .inc   (mem_read_en),
        .idx   (issue_idx),
        .done  (issue_done)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (capture),
        .inc   (write_data_array),
        .idx   (recv_idx),
        .done  (recv_done)
    );

`ifdef CACHE_FILL_CWF_EN
    // Both orders start at the missing word and wrap modulo the block size.
    logic [WORD_IDX_W-1:0] start_q;
    logic                  unused_addr_bit;

    assign unused_addr_bit = miss_address[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
        end else if (capture) begin
            start_q <= miss_address[OFFSET_BITS-1:1];
        end
    end

    assign issue_word = start_q + issue_idx;
    assign recv_word  = start_q + recv_idx;
`else
    logic [OFFSET_BITS-1:0] unused_offset;

    assign unused_offset = miss_address[OFFSET_BITS-1:0];
    assign issue_word    = issue_idx;
    assign recv_word     = recv_idx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                base_q <= {miss_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
        end
    end

    assign memory_address = base_q | ADDR_W'({issue_word, 1'b0});
    assign fill_word_sel  = recv_word;
    assign fill_data      = memory_data;

    always_comb begin
        state_d          = state_q;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    fsm_busy = miss_detected;
                    if (miss_detected) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    fsm_busy    = 1'b1;
                    mem_read_en = !issue_done;
                    // Returned words are counted independently of issues,
                    // so any memory latency is tolerated.
                    if (memory_data_valid && !recv_done) begin
                        write_data_array = 1'b1;
                        if (recv_idx == LAST_WORD) begin
                            state_d = TAG;
                        end
                    end
                end
                TAG: begin
                    fsm_busy        = 1'b1;
                    write_tag_array = 1'b1;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: constant vector table, directed
// multi-cycle fills and randomized traffic against a behavioural model.
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, miss_detected, memory_data_valid;
    logic [15:0] miss_address, memory_data;
    logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_data;
    logic [2:0]  fill_word_sel;

    always #5 clk = ~clk;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_sel     (fill_word_sel),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 waiting, 1 filling, 2 tag write.
    int m_phase = 0, m_base = 0, m_start = 0, m_issued = 0, m_recv = 0;
    logic e_busy, e_rd, e_wr, e_tag;

    // Observations gathered over one directed run.
    int obs_rd, obs_wr, obs_tag, obs_busy, obs_tag_cycle;
    int obs_addr[$];
    int obs_sel[$];

    function automatic int cwf_start(input logic [15:0] a);
        return CWF ? int'(a[3:1]) : 0;
    endfunction

    task automatic pre(input logic r, input logic m, input logic [15:0] a,
                       input logic v, input logic [15:0] d);
        rst = r; miss_detected = m; miss_address = a;
        memory_data_valid = v; memory_data = d;
        #3;
        e_busy = !r && (m_phase != 0 || m);
        e_rd   = !r && m_phase == 1 && m_issued < 8;
        e_wr   = !r && m_phase == 1 && v;
        e_tag  = !r && m_phase == 2;
        check("fsm_busy", fsm_busy, e_busy);
        check("mem_read_en", mem_read_en, e_rd);
        check("write_data_array", write_data_array, e_wr);
        check("write_tag_array", write_tag_array, e_tag);
        if (e_rd) check("memory_address", memory_address, m_base + 2 * ((m_start + m_issued) % 8));
        if (e_wr) begin
            check("fill_word_sel", fill_word_sel, (m_start + m_recv) % 8);
            check("fill_data", fill_data, d);
        end
        if (mem_read_en === 1'b1) begin obs_rd++; obs_addr.push_back(int'(memory_address)); end
        if (write_data_array === 1'b1) begin obs_wr++; obs_sel.push_back(int'(fill_word_sel)); end
        if (fsm_busy === 1'b1) obs_busy++;
    endtask

    task automatic post();
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_issued = 0; m_recv = 0;
        end else begin
            case (m_phase)
                0: if (miss_detected) begin
                    m_base = int'(miss_address) & 'hFFF0;
                    m_start = cwf_start(miss_address);
                    m_issued = 0; m_recv = 0; m_phase = 1;
                end
                1: begin
                    if (e_rd) m_issued++;
                    if (e_wr) begin
                        m_recv++;
                        if (m_recv == 8) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic clear_obs();
        obs_rd = 0; obs_wr = 0; obs_tag = 0; obs_busy = 0; obs_tag_cycle = -1;
        obs_addr.delete(); obs_sel.delete();
    endtask

    // mode 0: memory answers each read 4 cycles later; mode 1: fixed gapped pulses.
    task automatic run_miss(input logic [15:0] addr, input int mode,
                            input bit second_miss, input int rst_after);
        logic rdh[0:63];
        int gaps[8] = '{5, 7, 8, 11, 12, 14, 17, 18};
        int nvalid = 0;
        bit rst_done = 0;
        logic r, m, v;
        logic [15:0] a;
        clear_obs();
        for (int c = 0; c < 28; c++) begin
            m = (c == 0) || (second_miss && c == 3);
            a = (c == 0) ? addr : 16'h4000;
            v = 1'b0;
            if (mode == 0) v = (c >= 4) && rdh[c-4];
            else foreach (gaps[k]) if (gaps[k] == c) v = 1'b1;
            r = (rst_after > 0) && (nvalid == rst_after) && !rst_done;
            if (r) rst_done = 1;
            pre(r, m, a, v, 16'($urandom));
            rdh[c] = (mem_read_en === 1'b1);
            if (write_tag_array === 1'b1) begin obs_tag++; obs_tag_cycle = c; end
            post();
            if (v) nvalid++;
        end
    endtask

    typedef struct {
        logic r, m;
        logic [15:0] a;
        logic v;
        logic [15:0] d;
        logic eb, er, ew, et;
        logic [15:0] ea;
    } vec_t;

    vec_t tbl[8];
    int   sidx;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[4] = '{1'b0, 1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0,
                   CWF ? 16'h1236 : 16'h1230};
        tbl[6] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};

        for (int i = 0; i < 8; i++) begin
            pre(tbl[i].r, tbl[i].m, tbl[i].a, tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d busy", i), fsm_busy, tbl[i].eb);
            check($sformatf("tbl%0d rd", i), mem_read_en, tbl[i].er);
            check($sformatf("tbl%0d wr", i), write_data_array, tbl[i].ew);
            check($sformatf("tbl%0d tag", i), write_tag_array, tbl[i].et);
            if (tbl[i].er) check($sformatf("tbl%0d addr", i), memory_address, tbl[i].ea);
            post();
        end

        sidx = CWF ? 3 : 0;

        // Basic fill at 0x1236 with 4-cycle memory.
        run_miss(16'h1236, 0, 1'b0, 0);
        check("basic reads", obs_rd, 8);
        check("basic writes", obs_wr, 8);
        check("basic tag", obs_tag, 1);
        check("basic tag cycle", obs_tag_cycle, 13);
        check("basic busy cycles", obs_busy, 14);
        for (int i = 0; i < obs_addr.size() && i < 8; i++)
            check($sformatf("basic addr%0d", i), obs_addr[i], 'h1230 + 2 * ((sidx + i) % 8));
        for (int i = 0; i < obs_sel.size() && i < 8; i++)
            check($sformatf("basic sel%0d", i), obs_sel[i], (sidx + i) % 8);

        // Second miss during the fill must not disturb it.
        run_miss(16'h1236, 0, 1'b1, 0);
        check("miss2 reads", obs_rd, 8);
        check("miss2 writes", obs_wr, 8);
        check("miss2 tag", obs_tag, 1);
        foreach (obs_addr[i]) check($sformatf("miss2 base%0d", i), obs_addr[i] & 'hFFF0, 'h1230);

        // Reset after three returned words aborts the fill.
        run_miss(16'h1236, 0, 1'b0, 3);
        check("abort writes", obs_wr, 3);
        check("abort tag", obs_tag, 0);

        // Gapped valid pulses: tag follows only the 8th pulse (cycle 18).
        run_miss(16'h1236, 1, 1'b0, 0);
        check("gap writes", obs_wr, 8);
        check("gap tag", obs_tag, 1);
        check("gap tag cycle", obs_tag_cycle, 19);

        // Randomized traffic against the model.
        pre(1'b1, 1'b0, 16'h0, 1'b0, 16'h0); post();
        for (int c = 0; c < 3000; c++) begin
            logic v;
            if (m_phase == 1 && m_issued > m_recv) v = $urandom_range(0, 1) == 1;
            else v = $urandom_range(0, 9) == 0;
            pre($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                16'($urandom), v, 16'($urandom));
            post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
